stack_mon: RTL and testbench

//  Stack monitor sitting directly downstream of cpu_x: consumes its spx stack-pointer output every cycle.

---
 rtl/stack_mon.sv | 157 +++++++++++++++
 tb/tb_stack_mon.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_mon.sv
// Stack monitor for cpu_x: samples the stack pointer every cycle, flags overflow
// (below LIMIT) and hot-zone entry (below HOT), keeps a low watermark and exposes
// CTRL/LIMIT/HOT/MIN on a single-cycle-ack word bus. Flag rises produce trap pulses.
module stack_mon #(
    parameter logic [31:0] LIMIT_RST = 32'h0000_0000,
    parameter logic [31:0] HOT_RST   = 32'h0000_0000,
    parameter logic [31:0] WMARK_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] spx,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_din,
    output logic [31:0] bus_dout,
    output logic        bus_ack,
    output logic        trap_ovfl,
    output logic        trap_hot
);

    localparam logic [1:0] AddrCtrl  = 2'd0;
    localparam logic [1:0] AddrLimit = 2'd1;
    localparam logic [1:0] AddrHot   = 2'd2;
    localparam logic [1:0] AddrMin   = 2'd3;

    logic [31:0] r_spx;
    logic        r_en;
    logic        r_ovfl;
    logic        r_hot;
    logic [31:0] r_limit;
    logic [31:0] r_hot_thr;
    logic [31:0] r_min;
    logic        r_ack;
    logic [31:0] r_dout;
    logic        r_trap_ovfl;
    logic        r_trap_hot;

    logic        w_access;
    logic        w_wr_ctrl;
    logic        w_wr_limit;
    logic        w_wr_hot;
    logic        w_wr_min;
    logic        w_ovfl_set;
    logic        w_hot_set;
    logic        w_min_lower;
    logic        w_ovfl_view;
    logic        w_hot_view;
    logic [31:0] w_min_view;
    logic        w_ovfl_next;
    logic        w_hot_next;
    logic [31:0] w_rdata;

    // The ack cycle itself never opens a new access, so a held strobe cannot double-ack.
    assign w_access   = bus_stb & ~r_ack;
    assign w_wr_ctrl  = w_access & bus_we & (bus_addr == AddrCtrl);
    assign w_wr_limit = w_access & bus_we & (bus_addr == AddrLimit);
    assign w_wr_hot   = w_access & bus_we & (bus_addr == AddrHot);
    assign w_wr_min   = w_access & bus_we & (bus_addr == AddrMin);

    // Violation detection on the sampled pointer, unsigned compares, gated by enable.
    assign w_ovfl_set  = r_en & (r_spx < r_limit);
    assign w_hot_set   = r_en & (r_spx < r_hot_thr);
    assign w_min_lower = r_en & (r_spx < r_min);

    // Reads see this cycle's detection result, giving one cycle from spx to visible flag/MIN.
    assign w_ovfl_view = r_ovfl | w_ovfl_set;
    assign w_hot_view  = r_hot | w_hot_set;
    assign w_min_view  = w_min_lower ? r_spx : r_min;

    // A detection beats a simultaneous write-1-to-clear.
    assign w_ovfl_next = w_ovfl_set | (r_ovfl & ~(w_wr_ctrl & bus_din[1]));
    assign w_hot_next  = w_hot_set | (r_hot & ~(w_wr_ctrl & bus_din[2]));

    // Read data mux over the register map.
    always_comb begin
        w_rdata = '0;
        unique case (bus_addr)
            AddrCtrl:  w_rdata = {29'd0, w_hot_view, w_ovfl_view, r_en};
            AddrLimit: w_rdata = r_limit;
            AddrHot:   w_rdata = r_hot_thr;
            AddrMin:   w_rdata = w_min_view;
            default:   w_rdata = '0;
        endcase
    end

    // Pointer sampling stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_spx <= 32'hFFFF_FFFF;
        end else begin
            r_spx <= spx;
        end
    end

    // Control and threshold registers; enable is written directly, flags via detection/W1C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en      <= 1'b0;
            r_ovfl    <= 1'b0;
            r_hot     <= 1'b0;
            r_limit   <= LIMIT_RST;
            r_hot_thr <= HOT_RST;
        end else begin
            r_ovfl <= w_ovfl_next;
            r_hot  <= w_hot_next;
            if (w_wr_ctrl) begin
                r_en <= bus_din[0];
            end
            if (w_wr_limit) begin
                r_limit <= bus_din;
            end
            if (w_wr_hot) begin
                r_hot_thr <= bus_din;
            end
        end
    end

    // Watermark: a bus write takes priority over a lower sample in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_min <= WMARK_RST;
        end else if (w_wr_min) begin
            r_min <= bus_din;
        end else if (w_min_lower) begin
            r_min <= r_spx;
        end
    end

    // Bus response: one-cycle ack, read data only during the ack of a read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack  <= 1'b0;
            r_dout <= '0;
        end else begin
            r_ack  <= w_access;
            r_dout <= (w_access & ~bus_we) ? w_rdata : '0;
        end
    end

    // Trap pulses on each 0->1 flag transition only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trap_ovfl <= 1'b0;
            r_trap_hot  <= 1'b0;
        end else begin
            r_trap_ovfl <= w_ovfl_next & ~r_ovfl;
            r_trap_hot  <= w_hot_next & ~r_hot;
        end
    end

    assign bus_dout  = r_dout;
    assign bus_ack   = r_ack;
    assign trap_ovfl = r_trap_ovfl;
    assign trap_hot  = r_trap_hot;

endmodule

// File: tb/tb_stack_mon.sv
// Directed and randomized bench for stack_mon with a cycle-level behavioural model.
module tb_stack_mon;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] spx;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ack;
    logic        t_o;
    logic        t_h;

    stack_mon dut (
        .clk       (clk),
        .rst       (rst),
        .spx       (spx),
        .bus_stb   (stb),
        .bus_we    (we),
        .bus_addr  (addr),
        .bus_din   (din),
        .bus_dout  (dout),
        .bus_ack   (ack),
        .trap_ovfl (t_o),
        .trap_hot  (t_h)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_spx_r, m_limit, m_hotv, m_min, m_dout;
    logic        m_en, m_ovfl, m_hot, m_ack, m_to, m_th;
    int n_chk = 0;
    int n_err = 0;
    int cnt_to = 0;
    int cnt_th = 0;
    int cnt_ack = 0;
    logic [31:0] v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_spx_r = 32'hFFFF_FFFF;
        m_en = 0; m_ovfl = 0; m_hot = 0;
        m_limit = 0; m_hotv = 0; m_min = 32'hFFFF_FFFF;
        m_ack = 0; m_dout = 0; m_to = 0; m_th = 0;
    endtask

    // Advance one clock: predict from the pre-edge inputs, then compare all outputs.
    task automatic tick();
        logic        acc, wr, so, sh;
        logic [31:0] emin, rd;
        logic [31:0] n_min, n_limit, n_hotv;
        logic        n_en, n_ovfl, n_hot;
        acc  = stb && !m_ack;
        wr   = acc && we;
        so   = m_en && (m_spx_r < m_limit);
        sh   = m_en && (m_spx_r < m_hotv);
        emin = (m_en && m_spx_r < m_min) ? m_spx_r : m_min;
        case (addr)
            2'd0:    rd = {29'd0, m_hot || sh, m_ovfl || so, m_en};
            2'd1:    rd = m_limit;
            2'd2:    rd = m_hotv;
            default: rd = emin;
        endcase
        n_en    = (wr && addr == 2'd0) ? din[0] : m_en;
        n_limit = (wr && addr == 2'd1) ? din : m_limit;
        n_hotv  = (wr && addr == 2'd2) ? din : m_hotv;
        n_min   = (wr && addr == 2'd3) ? din : emin;
        n_ovfl  = so ? 1'b1 : ((wr && addr == 2'd0 && din[1]) ? 1'b0 : m_ovfl);
        n_hot   = sh ? 1'b1 : ((wr && addr == 2'd0 && din[2]) ? 1'b0 : m_hot);
        @(posedge clk);
        #1;
        if (!rst) begin
            m_reset();
        end else begin
            m_to = n_ovfl && !m_ovfl;
            m_th = n_hot && !m_hot;
            m_ack = acc;
            m_dout = (acc && !we) ? rd : 32'd0;
            m_spx_r = spx;
            m_en = n_en; m_limit = n_limit; m_hotv = n_hotv; m_min = n_min;
            m_ovfl = n_ovfl; m_hot = n_hot;
        end
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        chk("dout", dout, m_dout);
        chk("trap_ovfl", {31'd0, t_o}, {31'd0, m_to});
        chk("trap_hot", {31'd0, t_h}, {31'd0, m_th});
        if (t_o === 1'b1) cnt_to++;
        if (t_h === 1'b1) cnt_th++;
        if (ack === 1'b1) cnt_ack++;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        stb = 1; we = 1; addr = a; din = d;
        tick();
        chk("wr ack", {31'd0, ack}, 32'd1);
        stb = 0; we = 0;
        tick();
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        stb = 1; we = 0; addr = a;
        tick();
        chk("rd ack", {31'd0, ack}, 32'd1);
        d = dout;
        stb = 0;
        tick();
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        m_reset();
        repeat (2) tick();
        rst = 1;
    endtask

    initial begin
        // T1: reset held with a pending strobe
        m_reset();
        rst = 0; stb = 1; we = 0; addr = 2'd3; din = 0; spx = 32'h8000;
        repeat (3) tick();
        chk("T1 ack in reset", {31'd0, ack}, 32'd0);
        rst = 1; stb = 0;
        tick();
        bus_rd(2'd3, v);
        chk("T1 MIN after reset", v, 32'hFFFF_FFFF);

        // Reset during the ack cycle drops the access
        stb = 1; we = 1; addr = 2'd1; din = 32'h55;
        tick();
        rst = 0;
        #1;
        m_reset();
        chk("mid-reset ack", {31'd0, ack}, 32'd0);
        chk("mid-reset dout", dout, 32'd0);
        stb = 0; we = 0;
        tick();
        rst = 1;
        bus_rd(2'd1, v);
        chk("mid-reset LIMIT", v, 32'd0);

        // T2: bus write/read and held strobe
        bus_wr(2'd1, 32'h0000_1000);
        bus_rd(2'd1, v);
        chk("T2 LIMIT", v, 32'h0000_1000);
        cnt_ack = 0;
        stb = 1; we = 0; addr = 2'd1;
        repeat (2) tick();
        stb = 0;
        tick();
        chk("T2 one ack", cnt_ack, 32'd1);
        stb = 1;
        repeat (3) tick();
        stb = 0;
        tick();

        // T3: overflow detection; equality gives no flag
        bus_wr(2'd0, 32'h1);
        spx = 32'h1000;
        repeat (2) tick();
        bus_rd(2'd0, v);
        chk("T3 equal no flag", v, 32'h1);
        spx = 32'h0FFC;
        tick();
        chk("T3 trap at K+1", {31'd0, t_o}, 32'd0);
        stb = 1; we = 0; addr = 2'd0;
        tick();
        chk("T3 trap at K+2", {31'd0, t_o}, 32'd1);
        chk("T3 CTRL", dout, 32'h3);
        stb = 0;
        tick();
        chk("T3 trap single", {31'd0, t_o}, 32'd0);

        // T4: W1C while still violating, then after recovery
        cnt_to = 0;
        bus_wr(2'd0, 32'h3);
        bus_rd(2'd0, v);
        chk("T4 ovfl sticky", v, 32'h3);
        chk("T4 no repeat trap", cnt_to, 32'd0);
        spx = 32'h2000;
        tick();
        bus_wr(2'd0, 32'h3);
        bus_rd(2'd0, v);
        chk("T4 ovfl cleared", v, 32'h1);

        // T5: watermark
        spx = 32'hFFFF_FFFF;
        tick();
        bus_wr(2'd3, 32'hFFFF_FFFF);
        spx = 32'h8000; tick();
        spx = 32'h7F00; tick();
        spx = 32'h7F80; tick();
        bus_rd(2'd3, v);
        chk("T5 MIN", v, 32'h7F00);
        bus_wr(2'd0, 32'h0);
        spx = 32'h100;
        repeat (2) tick();
        bus_rd(2'd3, v);
        chk("T5 MIN hold en=0", v, 32'h7F00);
        bus_wr(2'd0, 32'h1);
        spx = 32'hFFFF_FFFF;
        bus_wr(2'd3, 32'hFFFF_FFFF);
        bus_rd(2'd3, v);
        chk("T5 write wins", v, 32'hFFFF_FFFF);

        // T6: hot zone then overflow
        do_reset();
        spx = 32'h9000;
        bus_wr(2'd2, 32'h2000);
        bus_wr(2'd1, 32'h1000);
        bus_wr(2'd0, 32'h1);
        cnt_to = 0; cnt_th = 0;
        spx = 32'h1800;
        repeat (3) tick();
        bus_rd(2'd0, v);
        chk("T6 hot only", v, 32'h5);
        chk("T6 hot traps", cnt_th, 32'd1);
        chk("T6 no ovfl trap", cnt_to, 32'd0);
        spx = 32'h0800;
        repeat (3) tick();
        bus_rd(2'd0, v);
        chk("T6 both flags", v, 32'h7);
        chk("T6 ovfl traps", cnt_to, 32'd1);
        chk("T6 hot no repeat", cnt_th, 32'd1);

        // Randomized phase, all outputs compared against the model every cycle
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int r;
            spx = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 32'h4000);
            r = $urandom_range(0, 4);
            if (r <= 1) begin
                tick();
            end else if (r == 2) begin
                logic [1:0] a;
                a = 2'($urandom_range(0, 3));
                if (a == 2'd0) bus_wr(a, $urandom_range(0, 7));
                else if (a == 2'd3 && $urandom_range(0, 1) == 1) bus_wr(a, 32'hFFFF_FFFF);
                else bus_wr(a, $urandom_range(0, 32'h4000));
            end else if (r == 3) begin
                bus_rd(2'($urandom_range(0, 3)), v);
            end else begin
                stb = 1; we = 0; addr = 2'($urandom_range(0, 3));
                repeat (3) tick();
                stb = 0;
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
